// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// FETCH_ADDR_W fixes the width of the address field stored with each word;
// the top-level ADDR_W parameter is expected to match it.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned WORD_BYTES   = 4;

    // One buffered instruction together with the byte address it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [31:0]             instr;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
// Flush wins over push and pop in the same cycle. Push and pop together on a
// full FIFO is allowed: the pop frees the slot the push fills.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  fetch_entry_t     i_data,
    output fetch_entry_t     o_head,
    output logic [CNT_W-1:0] o_count
);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign w_pop  = i_pop & (r_count != '0) & ~i_flush;
    assign w_push = i_push & ~i_flush & ((r_count != CNT_W'(DEPTH)) | w_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; cleared at reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer between the IF stage and a req/gnt/rvalid memory.
// Optional performance counters are compiled in with `define PREFETCH_PERF_EN.
//
// Handshakes: memory side, mem_req_o/mem_addr_o hold until mem_gnt_i (grant may
// arrive in the request cycle) and every grant is answered by exactly one
// mem_rvalid_i in order. Core side, a word transfers on any cycle where
// instr_valid_o & instr_ready_i; instr_valid_o never depends on instr_ready_i.
module instr_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_rdata_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_starve_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_discard;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_in_use;
    logic              w_grant;
    logic              w_keep;
    logic              w_pop;
    logic [CNT_W-1:0]  w_outstanding_nxt;
    logic [CNT_W-1:0]  w_discard_nxt;
    fetch_entry_t      w_entry;
    fetch_entry_t      w_head;

    // Credit: buffered plus in-flight words may never exceed DEPTH.
    assign w_in_use  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign mem_req_o = fetch_en_i & ~branch_i & (w_in_use < (CNT_W+1)'(DEPTH));
    assign mem_addr_o = r_req_pc;
    assign w_grant   = mem_req_o & mem_gnt_i;

    // A response is kept only once all stale (pre-redirect) responses are gone.
    assign w_keep = mem_rvalid_i & (r_discard == '0);
    assign w_pop  = instr_valid_o & instr_ready_i;

    assign w_entry.addr  = FETCH_ADDR_W'(r_rsp_pc);
    assign w_entry.instr = mem_rdata_i;

    assign instr_valid_o = (w_count != '0);
    assign instr_rdata_o = w_head.instr;
    assign instr_addr_o  = ADDR_W'(w_head.addr);

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_flush (branch_i),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Next outstanding/discard counts. On a redirect every response still in
    // flight after this cycle belongs to the old stream (including any already
    // marked for discard), so discard becomes the post-cycle outstanding count.
    // No grant can happen under a redirect, so that is outstanding minus this
    // cycle's response, and it is bounded by DEPTH through the credit check.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;
        case ({w_grant, mem_rvalid_i})
            2'b10:   w_outstanding_nxt = r_outstanding + CNT_W'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - CNT_W'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase
        if (branch_i) begin
            w_discard_nxt = w_outstanding_nxt;
        end else if (mem_rvalid_i && (r_discard != '0)) begin
            w_discard_nxt = r_discard - CNT_W'(1);
        end
    end

    // Request/response PCs and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_pc      <= BOOT_ADDR;
            r_rsp_pc      <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
            if (branch_i) begin
                r_req_pc <= branch_addr_i;
                r_rsp_pc <= branch_addr_i;
            end else begin
                if (w_grant) r_req_pc <= r_req_pc + ADDR_W'(WORD_BYTES);
                if (w_keep)  r_rsp_pc <= r_rsp_pc + ADDR_W'(WORD_BYTES);
            end
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_starve;

    // Words actually entering the FIFO, and cycles the core waited on us.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_starve  <= '0;
        end else begin
            if (w_keep && !branch_i)             r_perf_fetched <= r_perf_fetched + 32'd1;
            if (instr_ready_i && !instr_valid_o) r_perf_starve  <= r_perf_starve + 32'd1;
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_starve_o  = r_perf_starve;
`endif

    // A response must always answer an earlier grant.
    a_rvalid_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid_i |-> (r_outstanding != '0));

    // Credit accounting keeps buffered plus in-flight words within DEPTH.
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_in_use <= (CNT_W+1)'(DEPTH));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer (DEPTH 4, BOOT_ADDR 0x80).
// Memory model: grants when gnt_en, answers in order one or more cycles after
// grant when rsp_en. Build with PREFETCH_PERF_EN to include the counter test.
module tb_instr_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_addr_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_starve_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_gnt  = 0;
    int g0;

    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] pend_q[$];

    instr_prefetch_buffer #(
        .DEPTH     (4),
        .ADDR_W    (32),
        .BOOT_ADDR (32'h0000_0080)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_starve_o  (perf_starve_o)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        fetch_en_i    = 1'b0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_ready_i = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        gnt_en        = 1'b0;
        rsp_en        = 1'b0;
        pend_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // One clock: drive memory response/grant, observe at negedge, commit after posedge.
    task automatic tick();
        logic        granted;
        logic        rv;
        logic [31:0] gaddr;
        if (rsp_en && pend_q.size() != 0) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_q[0]);
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
        mem_gnt_i = gnt_en;
        @(negedge clk);
        granted = mem_req_o & mem_gnt_i;
        gaddr   = mem_addr_o;
        rv      = mem_rvalid_i;
        @(posedge clk);
        #1;
        if (rv) void'(pend_q.pop_front());
        if (granted) begin
            pend_q.push_back(gaddr);
            n_gnt++;
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_req", mem_req_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_rdata", instr_rdata_o, 0);
        check("rst_iaddr", instr_addr_o, 0);
        check("rst_maddr", mem_addr_o, 32'h80);

        // Sequential fetch, fill to DEPTH with ready low, then drain
        fetch_en_i = 1; gnt_en = 1; rsp_en = 1; instr_ready_i = 0; #1;
        check("t1_req0", mem_req_o, 1);
        check("t1_addr0", mem_addr_o, 32'h80);
        g0 = n_gnt;
        tick();
        check("t1_addr1", mem_addr_o, 32'h84);
        check("t1_valid_early", instr_valid_o, 0);
        tick();
        check("t1_valid", instr_valid_o, 1);
        check("t1_head0", instr_addr_o, 32'h80);
        check("t1_data0", instr_rdata_o, mem_word(32'h80));
        check("t1_addr2", mem_addr_o, 32'h88);
        tick();
        tick();
        check("t1_full_req", mem_req_o, 0);
        tick();
        tick();
        check("t1_grants", n_gnt - g0, 4);
        check("t1_full_req2", mem_req_o, 0);
        instr_ready_i = 1; #1;
        for (int k = 0; k < 4; k++) begin
            check("t1_drain_addr", instr_addr_o, 32'h80 + 4 * k);
            check("t1_drain_data", instr_rdata_o, mem_word(32'h80 + 4 * k));
            tick();
        end
        check("t1_resume_head", instr_addr_o, 32'h90);
        check("t1_resume_grants", n_gnt - g0, 7);

        // Redirect with two requests outstanding; reset mid-operation first
        do_reset();
        check("t2_rst_valid", instr_valid_o, 0);
        check("t2_rst_maddr", mem_addr_o, 32'h80);
        fetch_en_i = 1; gnt_en = 1; rsp_en = 0; instr_ready_i = 1; #1;
        tick();
        tick();
        branch_i = 1; branch_addr_i = 32'h200; #1;
        check("t2_br_req", mem_req_o, 0);
        g0 = n_gnt;
        tick();
        branch_i = 0; rsp_en = 1; #1;
        check("t2_br_nognt", n_gnt - g0, 0);
        check("t2_tgt_addr", mem_addr_o, 32'h200);
        check("t2_tgt_req", mem_req_o, 1);
        tick();
        check("t2_drop1", instr_valid_o, 0);
        tick();
        check("t2_drop2", instr_valid_o, 0);
        tick();
        check("t2_valid", instr_valid_o, 1);
        check("t2_head", instr_addr_o, 32'h200);
        check("t2_data", instr_rdata_o, mem_word(32'h200));

        // Redirect in the same cycle as a response and a pop
        do_reset();
        fetch_en_i = 1; gnt_en = 1; rsp_en = 1; instr_ready_i = 0; #1;
        tick();
        rsp_en = 0;
        tick();
        rsp_en = 1;
        tick();
        branch_i = 1; branch_addr_i = 32'h300; instr_ready_i = 1; #1;
        check("t3_pre_valid", instr_valid_o, 1);
        check("t3_br_req", mem_req_o, 0);
        g0 = n_gnt;
        tick();
        branch_i = 0; #1;
        check("t3_flushed", instr_valid_o, 0);
        check("t3_nognt", n_gnt - g0, 0);
        check("t3_tgt_addr", mem_addr_o, 32'h300);
        tick();
        check("t3_drop", instr_valid_o, 0);
        tick();
        check("t3_valid", instr_valid_o, 1);
        check("t3_head", instr_addr_o, 32'h300);

        // fetch_en dropped with one request outstanding
        do_reset();
        fetch_en_i = 1; gnt_en = 1; rsp_en = 0; instr_ready_i = 0; #1;
        g0 = n_gnt;
        tick();
        fetch_en_i = 0; rsp_en = 1; #1;
        check("t4_req_off", mem_req_o, 0);
        tick();
        check("t4_req_off2", mem_req_o, 0);
        check("t4_valid", instr_valid_o, 1);
        check("t4_head", instr_addr_o, 32'h80);
        tick();
        tick();
        check("t4_still_valid", instr_valid_o, 1);
        check("t4_grants", n_gnt - g0, 1);
        instr_ready_i = 1; #1;
        tick();
        check("t4_empty", instr_valid_o, 0);

        // Request held without grant, then address wrap
        do_reset();
        fetch_en_i = 1; gnt_en = 0; #1;
        tick();
        check("t5_hold_req", mem_req_o, 1);
        check("t5_hold_addr", mem_addr_o, 32'h80);
        tick();
        check("t5_hold_addr2", mem_addr_o, 32'h80);
        branch_i = 1; branch_addr_i = 32'hFFFF_FFFC;
        tick();
        branch_i = 0; gnt_en = 1; #1;
        check("t5_wrap_pre", mem_addr_o, 32'hFFFF_FFFC);
        tick();
        check("t5_wrap", mem_addr_o, 32'h0);

        // Back-to-back redirects with two requests in flight
        do_reset();
        fetch_en_i = 1; gnt_en = 1; rsp_en = 0; instr_ready_i = 1; #1;
        tick();
        tick();
        branch_i = 1; branch_addr_i = 32'h400;
        tick();
        branch_addr_i = 32'h500; #1;
        check("t6_br2_req", mem_req_o, 0);
        tick();
        branch_i = 0; rsp_en = 1; #1;
        check("t6_tgt_addr", mem_addr_o, 32'h500);
        tick();
        check("t6_drop1", instr_valid_o, 0);
        tick();
        check("t6_drop2", instr_valid_o, 0);
        tick();
        check("t6_valid", instr_valid_o, 1);
        check("t6_head", instr_addr_o, 32'h500);

`ifdef PREFETCH_PERF_EN
        // Performance counters: 3 starved cycles, then 4 words fetched
        do_reset();
        instr_ready_i = 1;
        tick();
        tick();
        tick();
        instr_ready_i = 0; fetch_en_i = 1; gnt_en = 1; rsp_en = 1;
        repeat (5) tick();
        check("t7_fetched", perf_fetched_o, 4);
        check("t7_starve", perf_starve_o, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
